// File: rtl/monster_renderer.sv
// ============================================================================
// Module   : monster_renderer
// Brief    : Per-line sprite list builder and 1-cycle pixel hit lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module monster_renderer #(
    parameter int MONSTERS = 12,
    parameter int REC_W    = 19,
    parameter int SPRITE   = 16
) (
    input  logic                      clk_game,
    input  logic                      rst,
    input  logic [MONSTERS*REC_W-1:0] state_monsters,
    input  logic                      line_start,
    input  logic [7:0]                line_y,
    input  logic                      pix_valid,
    input  logic [7:0]                pix_x,
    output logic                      line_ready,
    output logic                      hit,
    output logic [1:0]                hit_dir,
    output logic [3:0]                sprite_row,
    output logic [3:0]                sprite_col,
    output logic [3:0]                match_count
);

    localparam int c_idx_w = (MONSTERS > 1) ? $clog2(MONSTERS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(MONSTERS - 1);
    localparam logic [8:0] c_sprite9 = 9'(SPRITE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [MONSTERS*REC_W-1:0] snap_q, snap_d;
    logic [7:0]                line_y_q, line_y_d;
    logic [MONSTERS-1:0]       mask_q, mask_d;
    logic [3:0]                count_q, count_d;
    logic [c_idx_w-1:0]        idx_q, idx_d;
    logic                      line_ready_q, line_ready_d;
    logic                      hit_q, hit_d;
    logic [1:0]                hit_dir_q, hit_dir_d;
    logic [3:0]                sprite_row_q, sprite_row_d;
    logic [3:0]                sprite_col_q, sprite_col_d;

    logic                      w_alive [MONSTERS];
    logic [1:0]                w_dir   [MONSTERS];
    logic [7:0]                w_x     [MONSTERS];
    logic [7:0]                w_y     [MONSTERS];

    // Field views of the snapshot, not of the live input.
    for (genvar i = 0; i < MONSTERS; i++) begin : g_slot
        assign w_alive[i] = snap_q[i*REC_W];
        assign w_dir[i]   = snap_q[i*REC_W+1 +: 2];
        assign w_x[i]     = snap_q[i*REC_W+3 +: 8];
        assign w_y[i]     = snap_q[i*REC_W+11 +: 8];
    end

    logic       w_scan_match;
    logic [8:0] w_ly9;
    logic [8:0] w_sy9;

    always_comb begin
        w_ly9        = {1'b0, line_y_q};
        w_sy9        = {1'b0, w_y[idx_q]};
        w_scan_match = w_alive[idx_q] && (w_ly9 >= w_sy9) && (w_ly9 < w_sy9 + c_sprite9);
    end

    // Descending walk so the lowest matching slot is the one left selected.
    logic       w_pix_hit;
    logic [1:0] w_pix_dir;
    logic [3:0] w_pix_row;
    logic [3:0] w_pix_col;
    logic [8:0] w_px9;

    always_comb begin
        w_pix_hit = 1'b0;
        w_pix_dir = 2'd0;
        w_pix_row = 4'd0;
        w_pix_col = 4'd0;
        w_px9     = {1'b0, pix_x};
        for (int i = MONSTERS - 1; i >= 0; i--) begin
            if (mask_q[i] && (w_px9 >= {1'b0, w_x[i]}) &&
                (w_px9 < {1'b0, w_x[i]} + c_sprite9)) begin
                w_pix_hit = 1'b1;
                w_pix_dir = w_dir[i];
                w_pix_row = 4'(line_y_q - w_y[i]);
                w_pix_col = 4'(pix_x - w_x[i]);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        line_y_d = line_y_q;
        mask_d   = mask_q;
        count_d  = count_q;
        idx_d    = idx_q;
        if (line_start) begin
            state_d  = ST_SCAN;
            snap_d   = state_monsters;
            line_y_d = line_y;
            mask_d   = '0;
            count_d  = 4'd0;
            idx_d    = '0;
        end else if (state_q == ST_SCAN) begin
            if (w_scan_match) begin
                mask_d[idx_q] = 1'b1;
                count_d       = count_q + 4'd1;
            end
            if (idx_q == c_last_idx) begin
                state_d = ST_READY;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // A request is served from the list as it stands before this edge.
        hit_d        = 1'b0;
        hit_dir_d    = 2'd0;
        sprite_row_d = 4'd0;
        sprite_col_d = 4'd0;
        if ((state_q == ST_READY) && pix_valid && w_pix_hit) begin
            hit_d        = 1'b1;
            hit_dir_d    = w_pix_dir;
            sprite_row_d = w_pix_row;
            sprite_col_d = w_pix_col;
        end
        line_ready_d = (state_d == ST_READY);
    end

    always_ff @(posedge clk_game or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            snap_q       <= '0;
            line_y_q     <= 8'd0;
            mask_q       <= '0;
            count_q      <= 4'd0;
            idx_q        <= '0;
            line_ready_q <= 1'b0;
            hit_q        <= 1'b0;
            hit_dir_q    <= 2'd0;
            sprite_row_q <= 4'd0;
            sprite_col_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            line_y_q     <= line_y_d;
            mask_q       <= mask_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            line_ready_q <= line_ready_d;
            hit_q        <= hit_d;
            hit_dir_q    <= hit_dir_d;
            sprite_row_q <= sprite_row_d;
            sprite_col_q <= sprite_col_d;
        end
    end

    assign line_ready  = line_ready_q;
    assign hit         = hit_q;
    assign hit_dir     = hit_dir_q;
    assign sprite_row  = sprite_row_q;
    assign sprite_col  = sprite_col_q;
    assign match_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_monster_renderer.sv
// ============================================================================
// Module   : tb_monster_renderer
// Brief    : Directed and randomized checks of monster_renderer against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_monster_renderer;

    localparam int c_n   = 12;
    localparam int c_rec = 19;
    localparam int c_w   = c_n * c_rec;

    logic           clk_game = 1'b0;
    logic           rst = 1'b1;
    logic [c_w-1:0] state_monsters = '0;
    logic           line_start = 1'b0;
    logic [7:0]     line_y = 8'd0;
    logic           pix_valid = 1'b0;
    logic [7:0]     pix_x = 8'd0;
    logic           line_ready;
    logic           hit;
    logic [1:0]     hit_dir;
    logic [3:0]     sprite_row;
    logic [3:0]     sprite_col;
    logic [3:0]     match_count;

    int n_cmp = 0;
    int n_err = 0;

    // Model world: live monster table and the copy taken at line_start.
    int m_alive [c_n];
    int m_dir   [c_n];
    int m_x     [c_n];
    int m_y     [c_n];
    int s_alive [c_n];
    int s_dir   [c_n];
    int s_x     [c_n];
    int s_y     [c_n];
    int s_ly;

    monster_renderer #(.MONSTERS(c_n), .REC_W(c_rec), .SPRITE(16)) dut (
        .clk_game      (clk_game),
        .rst           (rst),
        .state_monsters(state_monsters),
        .line_start    (line_start),
        .line_y        (line_y),
        .pix_valid     (pix_valid),
        .pix_x         (pix_x),
        .line_ready    (line_ready),
        .hit           (hit),
        .hit_dir       (hit_dir),
        .sprite_row    (sprite_row),
        .sprite_col    (sprite_col),
        .match_count   (match_count)
    );

    always #5 clk_game = ~clk_game;

    task automatic tick();
        @(posedge clk_game);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_table();
        logic [c_w-1:0] v;
        v = '0;
        for (int i = 0; i < c_n; i++) begin
            v[i*c_rec]      = (m_alive[i] != 0);
            v[i*c_rec+1 +: 2] = 2'(m_dir[i]);
            v[i*c_rec+3 +: 8] = 8'(m_x[i]);
            v[i*c_rec+11 +: 8] = 8'(m_y[i]);
        end
        state_monsters = v;
    endtask

    task automatic clear_table();
        for (int i = 0; i < c_n; i++) begin
            m_alive[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        apply_table();
    endtask

    task automatic set_slot(input int i, input int a, input int d, input int x, input int y);
        m_alive[i] = a; m_dir[i] = d; m_x[i] = x; m_y[i] = y;
        apply_table();
    endtask

    function automatic int ref_count();
        int c;
        c = 0;
        for (int i = 0; i < c_n; i++)
            if (s_alive[i] != 0 && s_y[i] <= s_ly && s_ly < s_y[i] + 16) c++;
        return c;
    endfunction

    task automatic ref_pix(input int px, output int h, output int d, output int r, output int c);
        h = 0; d = 0; r = 0; c = 0;
        for (int i = 0; i < c_n; i++) begin
            if (h == 0 && s_alive[i] != 0 && s_y[i] <= s_ly && s_ly < s_y[i] + 16 &&
                s_x[i] <= px && px < s_x[i] + 16) begin
                h = 1; d = s_dir[i]; r = s_ly - s_y[i]; c = px - s_x[i];
            end
        end
    endtask

    // Drives a one-cycle line_start and leaves time just after that edge.
    task automatic pulse_line(input int ly);
        for (int i = 0; i < c_n; i++) begin
            s_alive[i] = m_alive[i]; s_dir[i] = m_dir[i]; s_x[i] = m_x[i]; s_y[i] = m_y[i];
        end
        s_ly = ly;
        line_start = 1'b1;
        line_y = 8'(ly);
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_ready(input int n0, input string tag);
        int n;
        n = n0;
        while (line_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, n, 13);
        chk({tag, "_count"}, match_count, ref_count());
    endtask

    task automatic lookup(input int valid, input int px, input string tag);
        int h, d, r, c;
        if (valid != 0) ref_pix(px, h, d, r, c);
        else begin h = 0; d = 0; r = 0; c = 0; end
        pix_valid = (valid != 0);
        pix_x = 8'(px);
        tick();
        chk({tag, "_hit"}, hit, h);
        chk({tag, "_dir"}, hit_dir, d);
        chk({tag, "_row"}, sprite_row, r);
        chk({tag, "_col"}, sprite_col, c);
    endtask

    initial begin
        int h, d, r, c, k;
        clear_table();
        tick();
        tick();
        chk("rst_ready", line_ready, 0);
        chk("rst_hit", hit, 0);
        chk("rst_count", match_count, 0);
        rst = 1'b0;
        tick();
        chk("idle_ready", line_ready, 0);

        // Single live slot, basic latency and lookup.
        set_slot(3, 1, 2, 73, 100);
        pulse_line(105);
        chk("scan_ready_low", line_ready, 0);
        wait_ready(1, "lat_basic");
        lookup(1, 80, "basic");
        chk("basic_abs_row", sprite_row, 5);
        chk("basic_abs_col", sprite_col, 7);
        lookup(0, 80, "novalid");

        // Request coincident with line_start: served from old list.
        pix_valid = 1'b1; pix_x = 8'd80;
        line_start = 1'b1; line_y = 8'd200;
        ref_pix(80, h, d, r, c);
        tick();
        line_start = 1'b0; pix_valid = 1'b0;
        s_ly = 200;
        chk("coin_hit", hit, h);
        chk("coin_row", sprite_row, r);
        chk("coin_ready", line_ready, 0);
        wait_ready(1, "lat_coin");

        // Two overlapping slots; lowest index wins, right edge exclusive.
        clear_table();
        set_slot(2, 1, 1, 14, 47);
        set_slot(7, 1, 3, 14, 47);
        pulse_line(50);
        wait_ready(1, "lat_two");
        lookup(1, 14, "two_left");
        chk("two_dir_abs", hit_dir, 1);
        lookup(1, 29, "two_last");
        lookup(1, 30, "two_out");
        chk("two_out_abs", hit, 0);

        // Dead slot never matches.
        clear_table();
        set_slot(0, 0, 2, 73, 105);
        pulse_line(105);
        wait_ready(1, "lat_dead");
        chk("dead_count_abs", match_count, 0);
        lookup(1, 73, "dead");

        // Snapshot isolation, request during SCAN dropped, restart mid-scan.
        clear_table();
        set_slot(3, 1, 2, 73, 100);
        pulse_line(105);
        set_slot(3, 0, 2, 73, 100);
        pix_valid = 1'b1; pix_x = 8'd80;
        tick();
        pix_valid = 1'b0;
        chk("scan_req_hit", hit, 0);
        wait_ready(2, "lat_snap");
        chk("snap_count_abs", match_count, 1);
        lookup(1, 80, "snap");
        set_slot(3, 1, 2, 73, 100);
        pulse_line(105);
        for (int i = 0; i < 4; i++) tick();
        pulse_line(106);
        wait_ready(1, "lat_restart");
        lookup(1, 88, "restart");

        // Bottom edge: no wrap past 255.
        clear_table();
        set_slot(5, 1, 3, 0, 250);
        pulse_line(255);
        wait_ready(1, "lat_edge");
        chk("edge_count_abs", match_count, 1);
        lookup(1, 5, "edge");
        chk("edge_row_abs", sprite_row, 5);
        pulse_line(4);
        wait_ready(1, "lat_nowrap");
        lookup(1, 5, "nowrap");

        // Asynchronous reset while READY with a hit registered.
        clear_table();
        set_slot(3, 1, 2, 73, 100);
        pulse_line(105);
        wait_ready(1, "lat_prerst");
        lookup(1, 80, "prerst");
        #2 rst = 1'b1;
        #1;
        chk("arst_hit", hit, 0);
        chk("arst_ready", line_ready, 0);
        chk("arst_count", match_count, 0);
        tick();
        rst = 1'b0;
        pix_valid = 1'b1; pix_x = 8'd80;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_hit", hit, 0);
            chk("postrst_ready", line_ready, 0);
        end
        pix_valid = 1'b0;
        pulse_line(105);
        wait_ready(1, "lat_postrst");
        lookup(1, 80, "postrst_line");

        // Randomized tables and back-to-back lookups.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < c_n; i++) begin
                m_alive[i] = int'($urandom_range(0, 1));
                m_dir[i]   = int'($urandom_range(0, 3));
                m_x[i]     = int'($urandom_range(0, 255));
                m_y[i]     = int'($urandom_range(0, 255));
            end
            apply_table();
            k = int'($urandom_range(0, c_n - 1));
            pulse_line((m_y[k] + int'($urandom_range(0, 17))) % 256);
            apply_table();
            wait_ready(1, "lat_rand");
            for (int j = 0; j < 24; j++) begin
                k = int'($urandom_range(0, c_n - 1));
                lookup(($urandom_range(0, 3) != 0) ? 1 : 0,
                       (s_x[k] + int'($urandom_range(0, 19))) % 256, "rand");
            end
        end
        pix_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/monster_renderer.md
MONSTER_RENDERER -- requirements
Module: monster_renderer

Interface
REQ-001 SHALL have parameter MONSTERS, default 12, meaning number of monster slots in the packed state vector.
REQ-002 SHALL have parameter REC_W, default 19, meaning bits per slot record.
REQ-003 SHALL have parameter SPRITE, default 16, meaning sprite edge length in pixels (square).
REQ-004 SHALL have port clk_game  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port state_monsters  input  MONSTERS*REC_W (228)  packed records; slot i = bits [i*19+18:i*19]: bit0 alive, [2:1] direction, [10:3] x, [18:11] y.
REQ-007 SHALL have port line_start  input  1  one-cycle pulse starting preparation of a new scan line.
REQ-008 SHALL have port line_y  input  8  line coordinate, sampled with line_start.
REQ-009 SHALL have port pix_valid  input  1  pixel lookup request this cycle.
REQ-010 SHALL have port pix_x  input  8  pixel column for the request.
REQ-011 SHALL have port line_ready  output  1  high while line list is valid and lookups are served.
REQ-012 SHALL have port hit  output  1  registered: requested pixel lies inside a live sprite.
REQ-013 SHALL have port hit_dir  output  2  direction field of hitting slot.
REQ-014 SHALL have port sprite_row  output  4  line_y minus slot y.
REQ-015 SHALL have port sprite_col  output  4  pix_x minus slot x.
REQ-016 SHALL have port match_count  output  4  number of slots intersecting the current line.

Function
REQ-017 SHALL implement FSM states IDLE, SCAN, READY; IDLE after reset.
REQ-018 SHALL, on line_start in any state, snapshot full state_monsters and line_y, clear match mask and match_count, set slot index 0, enter SCAN next cycle.
REQ-019 SHALL in SCAN examine one slot per cycle, index 0..MONSTERS-1 ascending, using the snapshot only (later state_monsters changes ignored until next line_start).
REQ-020 SHALL mark slot matched iff alive==1 and y <= line_y < y+SPRITE, compare done in 9-bit width (no wrap; y=250 covers lines 250..255 only).
REQ-021 SHALL increment match_count per matched slot, saturating impossible (max 12 fits 4 bits).
REQ-022 SHALL enter READY after slot MONSTERS-1 is examined: exactly MONSTERS cycles after the cycle following line_start; line_ready=1 only in READY.
REQ-023 SHALL, in READY, on pix_valid, register outputs next cycle: hit=1 iff some matched slot has x <= pix_x < x+SPRITE (9-bit compare); lowest-index such slot selects hit_dir, sprite_row, sprite_col.
REQ-024 SHALL drive hit=0, hit_dir/sprite_row/sprite_col=0 the cycle after pix_valid=0 or any request outside READY; requests outside READY are dropped, not queued.
REQ-025 SHALL accept back-to-back pix_valid every cycle in READY with 1-cycle latency, fully pipelined.
REQ-026 SHALL, on line_start during SCAN, abort and restart the scan; on line_start coincident with pix_valid in READY, serve that request from the old list and drop line_ready next cycle.
REQ-027 SHALL hold READY indefinitely until next line_start.

Reset
REQ-028 SHALL, on rst asserted (asynchronously), force IDLE, line_ready=0, hit=0, hit_dir=0, sprite_row=0, sprite_col=0, match_count=0, match mask and snapshot cleared.
REQ-029 SHALL, with rst asserted mid-SCAN or mid-READY, abandon the line; after release remain IDLE until line_start.

Verification
REQ-030 SHALL verify: slot 3 alive, x=73, y=100; line_start line_y=105 -> line_ready after 13 cycles, match_count=1; pix_x=80 -> hit=1, sprite_row=5, sprite_col=7, next cycle.
REQ-031 SHALL verify: slots 2 and 7 alive, both x=14, y=47; line_y=50, pix_x=14 -> hit=1 with slot 2 dir, sprite_col=0; pix_x=30 -> hit=0 (x+16 exclusive).
REQ-032 SHALL verify: slot 0 dead at x=73,y=105; line_y=105, pix_x=73 -> match_count=0, hit=0.
REQ-033 SHALL verify: line_start, state_monsters changed to clear slot 3 alive during SCAN -> slot 3 still matches (snapshot); second line_start at SCAN cycle 5 -> line_ready delayed, 13 cycles from second pulse.
REQ-034 SHALL verify: slot at y=250, line_y=255 -> match, sprite_row=5; line_y=4 -> no match (no wrap).
REQ-035 SHALL verify: rst pulse while READY with hit=1 -> hit, line_ready, match_count 0 immediately, pix_valid ignored until new line_start completes.
